shift_loader: RTL and testbench

SHIFT_LOADER -- requirements
Module: shift_loader

---
 rtl/shift_loader_pkg.sv | 20 ++
 rtl/byte_fifo2.sv | 69 ++++++
 rtl/shift_loader.sv | 128 ++++++++++++
 tb/tb_shift_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_loader_pkg.sv
// rtl/shift_loader_pkg.sv - shared types and constants for the shift loader
// Purpose: FSM state enum, byte width, FIFO depth and the buffered entry type.
// Ports: none (package).
package shift_loader_pkg;

  localparam int WIDTH      = 8;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // One buffered byte together with the direction it must be shifted in.
  typedef struct packed {
    logic             dir;
    logic [WIDTH-1:0] data;
  } entry_t;

endpackage

// File: rtl/byte_fifo2.sv
// rtl/byte_fifo2.sv - two-entry FIFO of {dir, data} entries
// Purpose: holds up to two pending bytes ahead of the serialiser.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset, empties the FIFO
//   push       in   write push_entry (ignored when full)
//   push_entry in   9-bit entry to write
//   pop        in   discard head (ignored when empty)
//   head       out  oldest entry, valid when count != 0
//   count      out  current occupancy 0..2
import shift_loader_pkg::*;

module byte_fifo2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  entry_t     push_entry,
  input  logic       pop,
  output entry_t     head,
  output logic [1:0] count
);

  localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

  entry_t     mem0_q, mem0_d;
  entry_t     mem1_q, mem1_d;
  logic [1:0] count_q, count_d;
  logic       do_push;
  logic       do_pop;

  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    do_push = push && (count_q != FULL_CNT);
    do_pop  = pop && (count_q != 2'd0);
    case ({do_push, do_pop})
      2'b10: begin
        if (count_q == 2'd0) mem0_d = push_entry;
        else                 mem1_d = push_entry;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        mem0_d  = mem1_q;
        count_d = count_q - 2'd1;
      end
      // Push with pop is only possible at occupancy 1: the new entry
      // replaces the departing head and occupancy is unchanged.
      2'b11: mem0_d = push_entry;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  assign head  = mem0_q;
  assign count = count_q;

endmodule

// File: rtl/shift_loader.sv
// rtl/shift_loader.sv - byte-to-serial loader for a bidirectional shift register
// Purpose: accepts bytes with a direction, buffers two, and drives a
//   downstream shift register so it ends holding each byte exactly.
// Ports:
//   Clk        in   clock, rising edge
//   Reset      in   synchronous active-high reset
//   data_in    in   byte to serialise
//   dir_in     in   1 = shift left (MSB first), 0 = shift right (LSB first)
//   valid_in   in   data_in/dir_in valid
//   ready_out  out  FIFO has room
//   SerOut     out  serial bit to shift register In
//   RLOut      out  direction to shift register RL
//   EnOut      out  shift enable to shift register En
//   busy       out  a byte is being shifted
//   done       out  last bit of a byte shifts on this edge
import shift_loader_pkg::*;

module shift_loader (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dir_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             SerOut,
  output logic             RLOut,
  output logic             EnOut,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             dir_q, dir_d;
  logic             ser_q, ser_d;
  logic             rl_q, rl_d;

  entry_t           fifo_head;
  entry_t           in_entry;
  entry_t           next_entry;
  logic [1:0]       fifo_count;
  logic             fifo_push;
  logic             fifo_pop;
  logic             accept;
  logic             at_end;
  logic             load;

  byte_fifo2 u_fifo (
    .clk        (Clk),
    .rst        (Reset),
    .push       (fifo_push),
    .push_entry (in_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .count      (fifo_count)
  );

  assign ready_out = (fifo_count != FULL_CNT);
  assign accept    = valid_in && ready_out;
  assign in_entry  = '{dir: dir_in, data: data_in};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    dir_d      = dir_q;
    next_entry = (fifo_count != 2'd0) ? fifo_head : in_entry;

    at_end = (state_q == SHIFT) && (cnt_q == 3'd7);
    // A new byte may start from idle or right after the 8th bit. When the
    // FIFO is empty the incoming byte bypasses it so its first bit appears
    // in the very next cycle.
    load = ((state_q == IDLE) || at_end) && ((fifo_count != 2'd0) || accept);

    fifo_pop  = load && (fifo_count != 2'd0);
    fifo_push = accept && !(load && (fifo_count == 2'd0));

    if (load) begin
      state_d = SHIFT;
      cnt_d   = 3'd0;
      sh_d    = next_entry.data;
      dir_d   = next_entry.dir;
    end else if (at_end) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else if (state_q == SHIFT) begin
      cnt_d = cnt_q + 3'd1;
    end

    // Serial outputs are registered from next-state values so they line up
    // with the state they describe.
    if (state_d == SHIFT) begin
      rl_d  = dir_d;
      ser_d = dir_d ? sh_d[3'd7 - cnt_d] : sh_d[cnt_d];
    end else begin
      rl_d  = rl_q;
      ser_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      sh_q    <= '0;
      dir_q   <= 1'b0;
      ser_q   <= 1'b0;
      rl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      dir_q   <= dir_d;
      ser_q   <= ser_d;
      rl_q    <= rl_d;
    end
  end

  assign SerOut = ser_q;
  assign RLOut  = rl_q;
  assign EnOut  = (state_q == SHIFT);
  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == SHIFT) && (cnt_q == 3'd7);

endmodule

// File: tb/tb_shift_loader.sv
// tb/tb_shift_loader.sv - self-checking bench for shift_loader
module tb_shift_loader;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] data_in;
  logic       dir_in;
  logic       valid_in;
  logic       ready_out;
  logic       SerOut;
  logic       RLOut;
  logic       EnOut;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  shift_loader dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .data_in   (data_in),
    .dir_in    (dir_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .SerOut    (SerOut),
    .RLOut     (RLOut),
    .EnOut     (EnOut),
    .busy      (busy),
    .done      (done)
  );

  always #5 Clk = ~Clk;

  // Downstream shift register: RL=1 shifts left (In -> Q[0]), RL=0 right (In -> Q[7]).
  logic [7:0] q_model = 8'h00;
  logic [7:0] got[$];
  int         done_cnt = 0;

  always @(posedge Clk) begin
    logic [7:0] nq;
    if (EnOut) begin
      nq = RLOut ? {q_model[6:0], SerOut} : {SerOut, q_model[7:1]};
      q_model <= nq;
      if (done) got.push_back(nq);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic       dir;
    logic [7:0] seq;   // seq[7] is the first bit expected on SerOut
    logic [7:0] q;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input logic [7:0] d, input logic dr, input logic [7:0] seq,
                         input logic [7:0] expq);
    data_in  = d;
    dir_in   = dr;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("vec%02h_en%0d", d, i), 32'(EnOut), 32'd1);
      check($sformatf("vec%02h_ser%0d", d, i), 32'(SerOut), 32'(seq[7-i]));
      check($sformatf("vec%02h_rl%0d", d, i), 32'(RLOut), 32'(dr));
      check($sformatf("vec%02h_done%0d", d, i), 32'(done), (i == 7) ? 32'd1 : 32'd0);
      tick();
    end
    check($sformatf("vec%02h_idle_en", d), 32'(EnOut), 32'd0);
    check($sformatf("vec%02h_idle_busy", d), 32'(busy), 32'd0);
    check($sformatf("vec%02h_rl_hold", d), 32'(RLOut), 32'(dr));
    check($sformatf("vec%02h_q", d), 32'(q_model), 32'(expq));
  endtask

  logic en_s[20], rl_s[20], ser_s[20], done_s[20];

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] qmid;
    logic [7:0] bytes_b[4];
    logic       bytes_d[4];
    logic [7:0] g;
    int         dc0, k, cyc, acc, saw_full;

    vecs[0] = '{data: 8'hA5, dir: 1'b1, seq: 8'b10100101, q: 8'hA5};
    vecs[1] = '{data: 8'h3C, dir: 1'b0, seq: 8'b00111100, q: 8'h3C};
    vecs[2] = '{data: 8'h80, dir: 1'b0, seq: 8'b00000001, q: 8'h80};
    vecs[3] = '{data: 8'h01, dir: 1'b1, seq: 8'b00000001, q: 8'h01};
    vecs[4] = '{data: 8'h6E, dir: 1'b0, seq: 8'b01110110, q: 8'h6E};

    Reset    = 1'b1;
    data_in  = 8'h00;
    dir_in   = 1'b0;
    valid_in = 1'b0;
    tick();
    tick();
    check("rst_en", 32'(EnOut), 32'd0);
    check("rst_ser", 32'(SerOut), 32'd0);
    check("rst_rl", 32'(RLOut), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(ready_out), 32'd1);
    Reset = 1'b0;
    tick();

    foreach (vecs[v]) run_vec(vecs[v].data, vecs[v].dir, vecs[v].seq, vecs[v].q);

    // Back-to-back FF (left) then 01 (right).
    dc0      = done_cnt;
    data_in  = 8'hFF;
    dir_in   = 1'b1;
    valid_in = 1'b1;
    tick();
    qmid = 8'h00;
    for (int i = 0; i < 20; i++) begin
      en_s[i]   = EnOut;
      rl_s[i]   = RLOut;
      ser_s[i]  = SerOut;
      done_s[i] = done;
      if (i == 8) qmid = q_model;
      if (i == 0) begin
        data_in = 8'h01;
        dir_in  = 1'b0;
      end else begin
        valid_in = 1'b0;
      end
      tick();
    end
    for (int i = 0; i < 17; i++)
      check($sformatf("b2b_en%0d", i), 32'(en_s[i]), (i < 16) ? 32'd1 : 32'd0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("b2b_rl%0d", i), 32'(rl_s[i]), (i < 8) ? 32'd1 : 32'd0);
      check($sformatf("b2b_ser%0d", i), 32'(ser_s[i]), (i <= 8) ? 32'd1 : 32'd0);
      check($sformatf("b2b_done%0d", i), 32'(done_s[i]), (i == 7 || i == 15) ? 32'd1 : 32'd0);
    end
    check("b2b_q_first", 32'(qmid), 32'hFF);
    check("b2b_q_second", 32'(q_model), 32'h01);
    check("b2b_done_pulses", 32'(done_cnt - dc0), 32'd2);

    // Four bytes with valid_in held: the FIFO fills and the last byte stalls.
    bytes_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    bytes_d = '{1'b1, 1'b0, 1'b1, 1'b0};
    got.delete();
    k = 0;
    cyc = 0;
    saw_full = 0;
    while (k < 4 && cyc < 100) begin
      data_in  = bytes_b[k];
      dir_in   = bytes_d[k];
      valid_in = 1'b1;
      acc      = int'(ready_out);
      if (!ready_out) saw_full = 1;
      tick();
      if (acc != 0) k++;
      cyc++;
    end
    valid_in = 1'b0;
    cyc = 0;
    while ((busy || got.size() < 4) && cyc < 200) begin
      tick();
      cyc++;
    end
    check("hold_all_accepted", 32'(k), 32'd4);
    check("hold_saw_full", 32'(saw_full), 32'd1);
    check("hold_got_count", 32'(got.size()), 32'd4);
    for (int j = 0; j < 4; j++) begin
      g = (j < got.size()) ? got[j] : 8'hxx;
      check($sformatf("hold_byte%0d", j), 32'(g), 32'(bytes_b[j]));
    end

    // Reset at bit 4 of C3, with a competing valid_in that must be dropped.
    dc0      = done_cnt;
    data_in  = 8'hC3;
    dir_in   = 1'b1;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    Reset    = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'h77;
    tick();
    Reset    = 1'b0;
    valid_in = 1'b0;
    check("abort_en", 32'(EnOut), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ser", 32'(SerOut), 32'd0);
    check("abort_rl", 32'(RLOut), 32'd0);
    check("abort_ready", 32'(ready_out), 32'd1);
    tick();
    tick();
    check("abort_no_pending", 32'(EnOut), 32'd0);
    check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    run_vec(8'h5A, 1'b0, 8'b01011010, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
